chess_clock_tc_ctrl: RTL and testbench
======================================

# chess_clock_tc_ctrl

Time-control controller for the two-player chess clock datapath. It sits between the debounced button drivers (`drv_switch` click pulses) and the two per-player `clock` dividers and `counter_dec_2w` down-counters. It arbitrates turns and issues per-player stop controls. After every completed move it sequences Fischer-increment credit onto the mover's counter as a train of `i_plus` pulses. It also detects flag fall.

## Interface
- `p_incr`, default 2: seconds credited to the mover per completed move (0..15).
- `p_moves`, default 40: own-move number at which the time-control bonus is credited (1..127).
- `p_bonus`, default 30: bonus seconds added on the `p_moves`-th own move (0..99).

Ports:
- `i_clk` in 1: system clock (50 MHz).
- `i_rst` in 1: reset, synchronous, active-high.
- `i_restart` in 1: restart click, single-cycle pulse.
- `i_pause` in 1: pause/resume click, single-cycle pulse.
- `i_move_a`, `i_move_b` in 1: move-done clicks, single-cycle pulses.
- `i_zero_a`, `i_zero_b` in 1: counter at 00 (level).
- `i_max_a`, `i_max_b` in 1: counter at 99 (level).
- `o_stop_a`, `o_stop_b` out 1: hold the player's `clock` divider.
- `o_plus_a`, `o_plus_b` out 1: single-cycle increment pulse to the player's counter.
- `o_restart` out 1: reload both counters/dividers.
- `o_flag_a`, `o_flag_b` out 1: player lost on time.
- `o_turn` out 1: 0 = A to move, 1 = B to move.
- `o_paused` out 1: pause state indicator.
- `o_moves` out 7: A's completed move count, saturating at 127.

## Operation
- States: IDLE, RUN_A, RUN_B, CREDIT, PAUSE, FLAG.
- IDLE:
  - Both clocks are stopped.
  - `i_move_b` goes to RUN_A; `i_move_a` goes to RUN_B (the opponent's press starts the clock).
  - Both move clicks in the same cycle are ignored.
- RUN_A:
  - `o_stop_a`=0 and `o_stop_b`=1.
  - `i_move_a` increments A's internal own-move count, loads credit k = `p_incr` (+`p_bonus` if the new count equals `p_moves`), and goes to CREDIT.
  - `i_move_b` is ignored.
  - RUN_B mirrors RUN_A.
- CREDIT:
  - Both clocks are stopped.
  - One `o_plus_<mover>` pulse per cycle, k pulses in total.
  - A pulse is suppressed while `i_max_<mover>`=1, and the remaining credit is discarded.
  - Then the state goes to RUN of the opponent.
  - If k=0, CREDIT is skipped.
- Flag fall: `i_zero_<runner>`=1 in RUN goes to FLAG with `o_flag_<runner>`=1. This takes priority over a same-cycle move click from the runner.
- `i_pause` in RUN goes to PAUSE. The turn is kept in `o_turn`. A second `i_pause` resumes the same RUN.
- `i_pause` is ignored in IDLE, CREDIT and FLAG.
- A move click in PAUSE is ignored. A move click wins over a same-cycle `i_pause`.
- FLAG: both clocks are stopped; only restart or reset exits.
- `i_restart` in any state:
  - Goes to IDLE and pulses `o_restart` for 1 cycle.
  - Clears the move counts and flags, and drops any pending credit.
  - Priority is below `i_rst` only.
- Own-move counts are 7 bits and saturate at 127. The bonus is applied exactly once per player per game.

## Timing
- All outputs are registered.
- Reset values:
  - `o_stop_a`=`o_stop_b`=1, `o_plus_*`=0, `o_flag_*`=0.
  - `o_turn`=0, `o_paused`=0, `o_moves`=0.
  - `o_restart`=1 while `i_rst`=1 and for the first cycle after release, then 0.
- Move click at cycle N:
  - Both stops are 1 from N+1.
  - `o_plus` pulses occur at N+1..N+k.
  - The opponent's stop goes to 0 at N+k+1 (N+1 when k=0).
  - `o_turn` flips at N+k+1.
- Zero-to-flag latency is 1 cycle. Pause/resume latency is 1 cycle.
- Restart click at N: `o_restart`=1 at N+1 only, state IDLE at N+1.
- Reset in mid-CREDIT: the pulse train stops immediately, with no further `o_plus`.

## Configuration
- `CHESS_CLOCK_BONUS_EN`:
  - Defined: `p_moves`/`p_bonus` bonus crediting is compiled in.
  - Undefined: k = `p_incr` always; `p_moves`/`p_bonus` are unused; `o_moves` still counts.

## Structure
- `chess_clock_pkg`:
  - State enum typedef `tc_state_t`.
  - Player index constants `PLAYER_A`=0, `PLAYER_B`=1.
  - Credit width constant `CREDIT_W`=7.
- Sub-module `chess_clock_credit`:
  - Loadable down-counter pulse generator with inputs load/value/abort/max and outputs pulse/done.
  - Instantiated once and shared by both players, muxed by the mover.

## Test plan
- Reset, then release → `o_restart`=1 for 1 cycle, both stops 1, all other outputs 0; `i_move_b` → `o_stop_a`=0 one cycle later, `o_turn`=0.
- RUN_A, `i_move_a` at N with `p_incr`=2 → `o_plus_a` at N+1 and N+2, `o_stop_b`=0 at N+3, `o_moves`=1.
- With the macro defined and `p_moves`=3 (default `p_incr`=2, `p_bonus`=30), A's 3rd move → 32 `o_plus_a` pulses. Without the macro → 2 pulses.
- `i_max_a`=1 after the 1st credit pulse → exactly 1 pulse, then RUN_B.
- RUN_B with `i_zero_b` and `i_move_b` in the same cycle → FLAG, `o_flag_b`=1, no `o_plus_b`; then `i_restart` → IDLE, flags 0, `o_restart` pulse.
- RUN_A, `i_pause` → both stops 1, `o_paused`=1; `i_move_a` ignored; `i_pause` → `o_stop_a`=0, `o_turn`=0.

Source files
------------

// File: rtl/chess_clock_pkg.sv
// Shared types and constants for the chess clock time-control controller.
`timescale 1ns/1ps
package chess_clock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN_A,
    ST_RUN_B,
    ST_CREDIT,
    ST_PAUSE,
    ST_FLAG
  } tc_state_t;

  localparam logic PLAYER_A = 1'b0;
  localparam logic PLAYER_B = 1'b1;

  localparam int CREDIT_W = 7;
  localparam int MOVE_W   = 7;

  // Move counters stick at their maximum instead of wrapping.
  function automatic logic [MOVE_W-1:0] sat_inc(input logic [MOVE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/chess_clock_credit.sv
// Loadable down-counter that emits one increment request per cycle until the
// credit is spent or the target counter reports it is full.
`timescale 1ns/1ps
module chess_clock_credit
  import chess_clock_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_load,
  input  logic [CREDIT_W-1:0] i_value,
  input  logic                i_abort,
  input  logic                i_max,
  output logic                o_pulse,
  output logic                o_done
);

  logic [CREDIT_W-1:0] remain;
  logic [CREDIT_W-1:0] avail;

  // A load is consumed in the same cycle, so the first pulse issues right away.
  assign avail   = i_load ? i_value : remain;
  assign o_pulse = (avail != '0) && !i_max && !i_abort;
  assign o_done  = !o_pulse;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_abort) begin
      remain <= '0;
    end else begin
      remain <= o_pulse ? avail - 1'b1 : '0;
    end
  end

endmodule

// File: rtl/chess_clock_tc_ctrl.sv
// Turn arbitration, Fischer-increment sequencing and flag detection for the chess clock.
// Optional move-count time-control bonus enabled by defining CHESS_CLOCK_BONUS_EN.
`timescale 1ns/1ps
module chess_clock_tc_ctrl
  import chess_clock_pkg::*;
#(
  parameter int unsigned p_incr  = 2,
  parameter int unsigned p_moves = 40,
  parameter int unsigned p_bonus = 30
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_restart,
  input  logic              i_pause,
  input  logic              i_move_a,
  input  logic              i_move_b,
  input  logic              i_zero_a,
  input  logic              i_zero_b,
  input  logic              i_max_a,
  input  logic              i_max_b,
  output logic              o_stop_a,
  output logic              o_stop_b,
  output logic              o_plus_a,
  output logic              o_plus_b,
  output logic              o_restart,
  output logic              o_flag_a,
  output logic              o_flag_b,
  output logic              o_turn,
  output logic              o_paused,
  output logic [MOVE_W-1:0] o_moves
);

  tc_state_t           state;
  logic [MOVE_W-1:0]   moves_b;
  logic                runner_b;
  logic                runner_zero;
  logic                runner_move;
  logic                mover_max;
  logic [MOVE_W-1:0]   mover_moves;
  logic [MOVE_W-1:0]   mover_moves_next;
  logic [CREDIT_W-1:0] credit_k;
  logic                credit_load;
  logic                credit_pulse;
  logic                credit_done;

  // NOTE: every always_comb variable gets a default first so no latch is inferred.
  always_comb begin
    runner_b         = (o_turn == PLAYER_B);
    runner_zero      = runner_b ? i_zero_b : i_zero_a;
    runner_move      = runner_b ? i_move_b : i_move_a;
    mover_max        = runner_b ? i_max_b  : i_max_a;
    mover_moves      = runner_b ? moves_b  : o_moves;
    mover_moves_next = sat_inc(mover_moves);
    credit_k         = CREDIT_W'(p_incr);
`ifdef CHESS_CLOCK_BONUS_EN
    // The saturation guard keeps the bonus to one award even when p_moves is 127.
    if (mover_moves != '1 && mover_moves_next == MOVE_W'(p_moves))
      credit_k = CREDIT_W'(p_incr + p_bonus);
`endif
    // Flag fall outranks a same-cycle move click from the runner.
    credit_load = (state == ST_RUN_A || state == ST_RUN_B) && runner_move && !runner_zero;
  end

`ifndef CHESS_CLOCK_BONUS_EN
  logic unused_params;
  assign unused_params = ^{p_moves, p_bonus};
`endif

  chess_clock_credit u_credit (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (credit_load),
    .i_value (credit_k),
    .i_abort (i_restart),
    .i_max   (mover_max),
    .o_pulse (credit_pulse),
    .o_done  (credit_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      o_stop_a  <= 1'b1;
      o_stop_b  <= 1'b1;
      o_plus_a  <= 1'b0;
      o_plus_b  <= 1'b0;
      o_restart <= 1'b1;
      o_flag_a  <= 1'b0;
      o_flag_b  <= 1'b0;
      o_turn    <= PLAYER_A;
      o_paused  <= 1'b0;
      o_moves   <= '0;
      moves_b   <= '0;
    end else begin
      o_plus_a  <= 1'b0;
      o_plus_b  <= 1'b0;
      o_restart <= 1'b0;
      if (i_restart) begin
        state     <= ST_IDLE;
        o_stop_a  <= 1'b1;
        o_stop_b  <= 1'b1;
        o_restart <= 1'b1;
        o_flag_a  <= 1'b0;
        o_flag_b  <= 1'b0;
        o_turn    <= PLAYER_A;
        o_paused  <= 1'b0;
        o_moves   <= '0;
        moves_b   <= '0;
      end else if (credit_load || state == ST_CREDIT) begin
        if (credit_load) begin
          if (runner_b) moves_b <= mover_moves_next;
          else          o_moves <= mover_moves_next;
        end
        if (credit_done) begin
          // Credit finished (or k=0 / counter full): hand the clock to the opponent.
          state    <= runner_b ? ST_RUN_A : ST_RUN_B;
          o_turn   <= !o_turn;
          o_stop_a <= !runner_b;
          o_stop_b <= runner_b;
        end else begin
          state    <= ST_CREDIT;
          o_stop_a <= 1'b1;
          o_stop_b <= 1'b1;
          o_plus_a <= !runner_b;
          o_plus_b <= runner_b;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            // The opponent's click starts the clock of the player to move.
            if (i_move_a ^ i_move_b) begin
              state    <= i_move_b ? ST_RUN_A : ST_RUN_B;
              o_turn   <= i_move_a;
              o_stop_a <= i_move_a;
              o_stop_b <= i_move_b;
            end
          end
          ST_RUN_A, ST_RUN_B: begin
            if (runner_zero) begin
              state    <= ST_FLAG;
              o_stop_a <= 1'b1;
              o_stop_b <= 1'b1;
              if (runner_b) o_flag_b <= 1'b1;
              else          o_flag_a <= 1'b1;
            end else if (i_pause) begin
              state    <= ST_PAUSE;
              o_stop_a <= 1'b1;
              o_stop_b <= 1'b1;
              o_paused <= 1'b1;
            end
          end
          ST_PAUSE: begin
            if (i_pause) begin
              state    <= runner_b ? ST_RUN_B : ST_RUN_A;
              o_paused <= 1'b0;
              o_stop_a <= runner_b;
              o_stop_b <= !runner_b;
            end
          end
          ST_FLAG: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chess_clock_tc_ctrl.sv
// Self-checking bench for chess_clock_tc_ctrl: directed vector table, multi-cycle
// sequences and a randomized run against a rule-level reference model.
`timescale 1ns/1ps
module tb_chess_clock_tc_ctrl;

  localparam int P_INCR  = 2;
  localparam int P_MOVES = 3;
  localparam int P_BONUS = 30;
`ifdef CHESS_CLOCK_BONUS_EN
  localparam bit BONUS_ON = 1'b1;
`else
  localparam bit BONUS_ON = 1'b0;
`endif

  typedef struct packed {
    logic rst, restart, pause, move_a, move_b, zero_a, zero_b, max_a, max_b;
  } in_t;

  typedef struct packed {
    logic stop_a, stop_b, plus_a, plus_b, restart, flag_a, flag_b, turn, paused;
    logic [6:0] moves;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  logic i_clk = 1'b0;
  logic i_rst, i_restart, i_pause, i_move_a, i_move_b, i_zero_a, i_zero_b, i_max_a, i_max_b;
  logic o_stop_a, o_stop_b, o_plus_a, o_plus_b, o_restart, o_flag_a, o_flag_b, o_turn, o_paused;
  logic [6:0] o_moves;
  out_t act;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  chess_clock_tc_ctrl #(.p_incr(P_INCR), .p_moves(P_MOVES), .p_bonus(P_BONUS)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_restart(i_restart), .i_pause(i_pause),
    .i_move_a(i_move_a), .i_move_b(i_move_b), .i_zero_a(i_zero_a), .i_zero_b(i_zero_b),
    .i_max_a(i_max_a), .i_max_b(i_max_b),
    .o_stop_a(o_stop_a), .o_stop_b(o_stop_b), .o_plus_a(o_plus_a), .o_plus_b(o_plus_b),
    .o_restart(o_restart), .o_flag_a(o_flag_a), .o_flag_b(o_flag_b), .o_turn(o_turn),
    .o_paused(o_paused), .o_moves(o_moves)
  );

  assign act = {o_stop_a, o_stop_b, o_plus_a, o_plus_b, o_restart, o_flag_a, o_flag_b,
                o_turn, o_paused, o_moves};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Inputs change 1ns after the active edge; outputs are sampled at the same point.
  task automatic step(input in_t v);
    {i_rst, i_restart, i_pause, i_move_a, i_move_b, i_zero_a, i_zero_b, i_max_a, i_max_b} = v;
    @(posedge i_clk);
    #1;
  endtask

  task automatic move_and_count(input logic player_b, output int pulses);
    in_t v;
    v = '0;
    if (player_b) v.move_b = 1'b1;
    else          v.move_a = 1'b1;
    pulses = 0;
    step(v);
    v = '0;
    for (int c = 0; c < 200; c++) begin
      if (player_b ? o_plus_b : o_plus_a) pulses++;
      if (!(player_b ? o_stop_a : o_stop_b)) break;
      step(v);
    end
    check("handover_after_credit", {31'd0, player_b ? o_stop_a : o_stop_b}, 32'd0);
  endtask

  // Reference model: game phase flags, owed credit and per-player move tallies.
  bit   m_started, m_credit, m_flagged, m_paused, m_turn;
  int   m_owed;
  int   m_moves[2];
  out_t m_out;

  task automatic model_credit_tick(input in_t v);
    logic full;
    full = m_turn ? v.max_b : v.max_a;
    if (m_owed > 0 && !full) begin
      if (m_turn) m_out.plus_b = 1'b1;
      else        m_out.plus_a = 1'b1;
      m_owed--;
    end else begin
      m_credit = 1'b0;
      m_owed   = 0;
      m_turn   = !m_turn;
    end
  endtask

  task automatic model_step(input in_t v);
    int  r;
    bit  bonus;
    m_out.plus_a  = 1'b0;
    m_out.plus_b  = 1'b0;
    m_out.restart = 1'b0;
    if (v.rst || v.restart) begin
      m_started = 0; m_credit = 0; m_flagged = 0; m_paused = 0; m_turn = 0;
      m_owed = 0; m_moves[0] = 0; m_moves[1] = 0;
      m_out.flag_a = 0; m_out.flag_b = 0; m_out.restart = 1'b1;
    end else if (m_flagged) begin
    end else if (!m_started) begin
      if (v.move_a != v.move_b) begin
        m_started = 1'b1;
        m_turn    = v.move_a;
      end
    end else if (m_paused) begin
      if (v.pause) m_paused = 1'b0;
    end else if (m_credit) begin
      model_credit_tick(v);
    end else begin
      r = m_turn ? 1 : 0;
      if (r == 1 ? v.zero_b : v.zero_a) begin
        m_flagged = 1'b1;
        if (r == 1) m_out.flag_b = 1'b1;
        else        m_out.flag_a = 1'b1;
      end else if (r == 1 ? v.move_b : v.move_a) begin
        bonus = (m_moves[r] < 127) && (m_moves[r] + 1 == P_MOVES);
        if (m_moves[r] < 127) m_moves[r]++;
        m_owed   = P_INCR + ((BONUS_ON && bonus) ? P_BONUS : 0);
        m_credit = 1'b1;
        model_credit_tick(v);
      end else if (v.pause) begin
        m_paused = 1'b1;
      end
    end
    m_out.stop_a = !(m_started && !m_credit && !m_paused && !m_flagged && m_turn == 1'b0);
    m_out.stop_b = !(m_started && !m_credit && !m_paused && !m_flagged && m_turn == 1'b1);
    m_out.turn   = m_turn;
    m_out.paused = m_paused;
    m_out.moves  = 7'(m_moves[0]);
  endtask

  vec_t tbl[25];

  initial begin
    in_t v;
    int  pulses;
    int  exp_pulses;

    // in : rst rsc pz ma mb za zb xa xb   out: sa sb pa pb rs fa fb t p , moves
    tbl[0]  = '{9'b1_0_0_0_0_0_0_0_0, {9'b1_1_0_0_1_0_0_0_0, 7'd0}};
    tbl[1]  = '{9'b1_0_0_0_0_0_0_0_0, {9'b1_1_0_0_1_0_0_0_0, 7'd0}};
    tbl[2]  = '{9'b0_0_0_0_0_0_0_0_0, {9'b1_1_0_0_0_0_0_0_0, 7'd0}};
    tbl[3]  = '{9'b0_0_0_0_1_0_0_0_0, {9'b0_1_0_0_0_0_0_0_0, 7'd0}};
    tbl[4]  = '{9'b0_0_0_0_1_0_0_0_0, {9'b0_1_0_0_0_0_0_0_0, 7'd0}};
    tbl[5]  = '{9'b0_0_0_1_0_0_0_0_0, {9'b1_1_1_0_0_0_0_0_0, 7'd1}};
    tbl[6]  = '{9'b0_0_0_0_0_0_0_0_0, {9'b1_1_1_0_0_0_0_0_0, 7'd1}};
    tbl[7]  = '{9'b0_0_0_0_0_0_0_0_0, {9'b1_0_0_0_0_0_0_1_0, 7'd1}};
    tbl[8]  = '{9'b0_0_1_0_0_0_0_0_0, {9'b1_1_0_0_0_0_0_1_1, 7'd1}};
    tbl[9]  = '{9'b0_0_0_0_1_0_0_0_0, {9'b1_1_0_0_0_0_0_1_1, 7'd1}};
    tbl[10] = '{9'b0_0_1_0_0_0_0_0_0, {9'b1_0_0_0_0_0_0_1_0, 7'd1}};
    tbl[11] = '{9'b0_0_1_0_1_0_0_0_0, {9'b1_1_0_1_0_0_0_1_0, 7'd1}};
    tbl[12] = '{9'b0_0_0_0_0_0_0_0_0, {9'b1_1_0_1_0_0_0_1_0, 7'd1}};
    tbl[13] = '{9'b0_0_0_0_0_0_0_0_0, {9'b0_1_0_0_0_0_0_0_0, 7'd1}};
    tbl[14] = '{9'b0_0_0_1_0_0_0_1_0, {9'b1_0_0_0_0_0_0_1_0, 7'd2}};
    tbl[15] = '{9'b0_0_0_0_1_0_1_0_0, {9'b1_1_0_0_0_0_1_1_0, 7'd2}};
    tbl[16] = '{9'b0_0_1_0_0_0_0_0_0, {9'b1_1_0_0_0_0_1_1_0, 7'd2}};
    tbl[17] = '{9'b0_1_0_0_0_0_0_0_0, {9'b1_1_0_0_1_0_0_0_0, 7'd0}};
    tbl[18] = '{9'b0_0_0_0_0_0_0_0_0, {9'b1_1_0_0_0_0_0_0_0, 7'd0}};
    tbl[19] = '{9'b0_0_0_1_1_0_0_0_0, {9'b1_1_0_0_0_0_0_0_0, 7'd0}};
    tbl[20] = '{9'b0_0_0_1_0_0_0_0_0, {9'b1_0_0_0_0_0_0_1_0, 7'd0}};
    tbl[21] = '{9'b0_0_0_0_0_0_0_0_0, {9'b1_0_0_0_0_0_0_1_0, 7'd0}};
    tbl[22] = '{9'b0_0_0_0_0_1_0_0_0, {9'b1_0_0_0_0_0_0_1_0, 7'd0}};
    tbl[23] = '{9'b0_0_0_0_0_0_1_0_0, {9'b1_1_0_0_0_0_1_1_0, 7'd0}};
    tbl[24] = '{9'b0_1_0_0_0_0_0_0_0, {9'b1_1_0_0_1_0_0_0_0, 7'd0}};

    for (int i = 0; i < 25; i++) begin
      step(tbl[i].in);
      check($sformatf("vec%0d", i), 32'(act), 32'(tbl[i].exp));
    end

    // Increment and time-control bonus: three moves per player from a fresh game.
    v = '0; v.move_b = 1'b1;
    step(v);
    check("start_run_a", {30'd0, o_stop_a, o_turn}, 32'd0);
    for (int m = 1; m <= 3; m++) begin
      exp_pulses = (BONUS_ON && m == P_MOVES) ? P_INCR + P_BONUS : P_INCR;
      move_and_count(1'b0, pulses);
      check($sformatf("pulses_a_move%0d", m), 32'(pulses), 32'(exp_pulses));
      move_and_count(1'b1, pulses);
      check($sformatf("pulses_b_move%0d", m), 32'(pulses), 32'(exp_pulses));
    end
    check("moves_after_three", 32'(o_moves), 32'd3);

    // Counter reaches 99 right after the first credit pulse.
    v = '0; v.move_a = 1'b1;
    step(v);
    check("max_first_pulse", {31'd0, o_plus_a}, 32'd1);
    v = '0; v.max_a = 1'b1;
    step(v);
    check("max_abort", {29'd0, o_plus_a, o_stop_b, o_turn}, 32'd1);
    v = '0;
    step(v);
    check("max_after", {30'd0, o_plus_a, o_stop_a}, 32'd1);

    // Reset in the middle of a credit train.
    v = '0; v.move_b = 1'b1;
    step(v);
    check("credit_b_started", {31'd0, o_plus_b}, 32'd1);
    v = '0; v.rst = 1'b1;
    step(v);
    check("reset_mid_credit", {28'd0, o_plus_b, o_restart, o_stop_a, o_stop_b}, 32'h7);
    v = '0;
    step(v);
    check("after_reset_release", {23'd0, o_plus_b, o_restart, o_moves}, 32'd0);

    // Randomized run against the reference model.
    for (int c = 0; c < 4000; c++) begin
      v         = '0;
      v.rst     = (c == 0) || ($urandom_range(399) == 0);
      v.restart = ($urandom_range(79) == 0);
      v.pause   = ($urandom_range(19) == 0);
      v.move_a  = ($urandom_range(5) == 0);
      v.move_b  = ($urandom_range(5) == 0);
      v.zero_a  = ($urandom_range(49) == 0);
      v.zero_b  = ($urandom_range(49) == 0);
      v.max_a   = ($urandom_range(14) == 0);
      v.max_b   = ($urandom_range(14) == 0);
      model_step(v);
      step(v);
      check($sformatf("random_cycle%0d", c), 32'(act), 32'(m_out));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
